data_memory_bcd: RTL
====================

Name: data_memory_bcd

Overview:
Parametrised byte-addressed data memory for the RV32 core. Supports RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes, sign/zero extension and misalignment detection. Contains a sequential double-dabble engine that converts a snapshot of any memory word to DIGITS packed BCD digits for the board's 7-segment display. Sits between the ALU result/rs2 path and the writeback mux; the BCD output feeds the display driver.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two).
DIGITS, 4, BCD digits produced by the conversion engine (1..10).

Ports:
clk  input  1  clock.
rst  input  1  reset, asynchronous, active-low.
addr  input  32  byte address for core access.
wdata  input  32  store data, right-aligned.
we  input  1  store enable.
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
rdata  output  32  load data, extended.
misaligned  output  1  current access is misaligned or has an illegal funct3.
disp_req  input  1  start a BCD conversion (accepted only when idle).
disp_addr  input  32  byte address of the word to convert; bits [1:0] are ignored.
disp_busy  output  1  conversion in progress.
disp_valid  output  1  one-cycle pulse when disp_bcd/disp_ovf update.
disp_bcd  output  4*DIGITS  packed BCD, least-significant digit in [3:0].
disp_ovf  output  1  converted value was >= 10^DIGITS.

Behaviour:
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Reset does not touch array contents; the array stays RAM-inferable.
- Reset drives disp_busy=0, disp_valid=0, disp_bcd=0, disp_ovf=0, FSM=IDLE.
- Read path is combinational:
  - Selected byte = word[8*addr[1:0]+:8]; selected half = word[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W returns the whole word.
- misaligned=1 when any of the following holds:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 is 011, 110 or 111.
- When misaligned=1, rdata=0 and any store is suppressed.
- Store is synchronous at posedge clk when we=1 and misaligned=0. funct3 selects the lanes written:
  - SB: wdata[7:0] into lane addr[1:0].
  - SH: wdata[15:0] into half addr[1].
  - SW: all 4 lanes.
  - Unwritten lanes are preserved.
- Read-during-write: rdata shows the old contents until the clock edge.
- BCD FSM states: IDLE, SHIFT, DONE.
- IDLE: if disp_req=1 at a posedge (edge N):
  - Snapshot the word at disp_addr. A store to the same word in that same cycle is not reflected; the old value is captured.
  - Clear the BCD accumulator and the sticky carry, load counter=32, go to SHIFT.
  - disp_busy=1 from edge N.
- SHIFT: one bit per cycle, MSB first.
  - Add 3 to each accumulator digit >= 5, then shift the accumulator left taking in the next snapshot bit.
  - The bit shifted out of the top digit ORs into the sticky carry.
  - After 32 shifts (edge N+32) go to DONE.
- DONE (edge N+33):
  - Register disp_bcd = accumulator (value mod 10^DIGITS) and disp_ovf = sticky carry.
  - Pulse disp_valid for exactly one cycle, drop disp_busy, return to IDLE.
  - Total latency is 33 cycles from the accepting edge to disp_valid.
- disp_req while busy is ignored, with no queuing. A disp_req in the disp_valid cycle is accepted (FSM is IDLE).
- disp_bcd and disp_ovf hold their last values between conversions.
- Value is treated as unsigned 32-bit.
- Reset asserted mid-conversion: immediate return to reset values; the conversion is abandoned and no valid pulse is produced.

Test Plan:
1. SW 0x12345678 @0x10, then LW 0x10 -> 0x12345678; LB 0x13 -> 0x00000012; LHU 0x12 -> 0x00001234; LB 0x10 -> 0x00000078.
2. SB 0x80 @0x21 over word 0 -> word 0x00008000. LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LH 0x20 -> 0xFFFF8000.
3. LW @0x12, SH @0x13, funct3=011 -> misaligned=1, rdata=0, and word contents unchanged after a we=1 cycle.
4. Word = 1234, disp_req -> disp_busy for 33 cycles, disp_valid one cycle with disp_bcd=0x1234, disp_ovf=0. A second req at cycle 5 of the conversion is ignored.
5. Word = 12345 -> disp_bcd=0x2345, disp_ovf=1. Word = 0xFFFFFFFF -> disp_bcd=0x7295, disp_ovf=1. Word = 9999 -> 0x9999, disp_ovf=0.
6. Assert rst at cycle 10 of a conversion -> busy/valid/bcd/ovf = 0 immediately, no later valid pulse, and memory word still readable unchanged. Also: store to the same word in the disp_req cycle -> old value is converted.

Source files
------------

// File: rtl/data_memory_bcd.sv
// Byte-addressed data memory for the RV32 core with RV32I load/store
// width handling and a sequential binary-to-BCD (double dabble) engine
// that converts a snapshot of one memory word for the 7-segment display.
module data_memory_bcd #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic                  we,
    input  logic [2:0]            funct3,
    output logic [31:0]           rdata,
    output logic                  misaligned,
    input  logic                  disp_req,
    input  logic [31:0]           disp_addr,
    output logic                  disp_busy,
    output logic                  disp_valid,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  disp_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [AW-1:0] disp_idx;
    logic [31:0]   word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          mis;
    logic [31:0]   rdata_d;
    logic [3:0]    be;
    logic [31:0]   wlane;

    state_t        state_q;
    logic [31:0]   snap_q;
    logic [BW-1:0] acc_q;
    logic [BW-1:0] acc_adj;
    logic [BW-1:0] acc_d;
    logic          carry_q;
    logic          carry_d;
    logic [5:0]    cnt_q;
    logic          busy_q;
    logic          valid_q;
    logic [BW-1:0] bcd_q;
    logic          ovf_q;

    // Address bits above the array size and the byte offset of the display
    // address do not take part in any decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], disp_addr[31:AW+2], disp_addr[1:0]};

    assign word_idx = addr[AW+1:2];
    assign disp_idx = disp_addr[AW+1:2];
    assign word     = mem[word_idx];
    assign sel_byte = word[{addr[1:0], 3'b000} +: 8];
    assign sel_half = word[{addr[1], 4'b0000} +: 16];

    // Misalignment / illegal-size decode
    always_comb begin
        mis = 1'b0;
        case (funct3)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = addr[0];
            3'b010:         mis = |addr[1:0];
            default:        mis = 1'b1;
        endcase
    end

    // Combinational load path with sign/zero extension
    always_comb begin
        rdata_d = '0;
        case (funct3)
            3'b000:  rdata_d = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  rdata_d = {{16{sel_half[15]}}, sel_half};
            3'b010:  rdata_d = word;
            3'b100:  rdata_d = {24'h000000, sel_byte};
            3'b101:  rdata_d = {16'h0000, sel_half};
            default: rdata_d = '0;
        endcase
        if (mis) begin
            rdata_d = '0;
        end
    end

    assign rdata      = rdata_d;
    assign misaligned = mis;

    // Store byte enables and lane-replicated store data
    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wlane = wdata;
            end
            default: be = 4'b0000;
        endcase
    end

    // Byte-lane store; no reset so the array stays RAM-inferable
    always_ff @(posedge clk) begin
        if (we && !mis) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    // Double-dabble step: add 3 to digits >= 5, then shift in the next bit;
    // anything leaving the top digit means the value needs more digits.
    always_comb begin
        acc_adj = acc_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_d   = {acc_adj[BW-2:0], snap_q[31]};
        carry_d = carry_q | acc_adj[BW-1];
    end

    // Conversion FSM with registered display outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (disp_req) begin
                        snap_q  <= mem[disp_idx];
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= 6'd32;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    snap_q  <= {snap_q[30:0], 1'b0};
                    cnt_q   <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= acc_q;
                    ovf_q   <= carry_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign disp_busy  = busy_q;
    assign disp_valid = valid_q;
    assign disp_bcd   = bcd_q;
    assign disp_ovf   = ovf_q;

endmodule
